mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

- Sequences load/store accesses from the MEM stage onto an external request/acknowledge data bus.
- Holds the pipeline via `stallreq` until the access completes, then presents load data.
- Tolerates pipeline stalls from other sources while data is pending.
- Handles exception flushes of an in-flight access and bus timeouts.
- Sits between the MEM stage and the data-memory bus; `stallreq` feeds the pipeline control block.

## Interface

Parameters:
- `TIMEOUT`, default 255: bus cycles allowed without `bus_ack` before the access is abandoned. Range 2..255.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_req` in 1: MEM stage holds a load/store this cycle.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in 32: byte address.
- `mem_sel` in 4: byte lane enables.
- `mem_wdata` in 32: store data.
- `stall_i` in 1: pipeline stalled; MEM-stage registers do not advance this cycle.
- `flush` in 1: exception flush of the current MEM instruction.
- `stallreq` out 1: stall request to pipeline control.
- `mem_rdata` out 32: load data, valid while in DONE.
- `bus_err` out 1: one-cycle pulse on timeout.
- `bus_stb` out 1: bus request, registered.
- `bus_we` out 1: bus write, registered.
- `bus_addr` out 32: bus address, registered.
- `bus_sel` out 4: bus byte lanes, registered.
- `bus_wdata` out 32: bus write data, registered.
- `bus_ack` in 1: slave completion; may arrive in the same cycle `bus_stb` is first seen high.
- `bus_rdata` in 32: read data, valid with `bus_ack`.

## Operation

States: IDLE, BUSY, ABORT, DONE.

- **IDLE**
  - `mem_req && !flush` → latch `we/addr/sel/wdata` into the bus registers, set `bus_stb`, clear the timeout counter, go to BUSY.
  - `stallreq = mem_req && !flush`.
- **BUSY**
  - `stallreq = 1`. The counter increments every cycle.
  - `bus_ack` → clear `bus_stb`, capture `bus_rdata` (stores capture 0), go to DONE.
  - `flush` without `bus_ack` → go to ABORT. The transaction stays on the bus; a slave access is never cut mid-cycle.
  - `flush` and `bus_ack` in the same cycle → clear `bus_stb`, go to IDLE, discard data.
  - Counter reaches `TIMEOUT-1` without ack → clear `bus_stb`, pulse `bus_err`, set captured data to 0, go to DONE.
- **ABORT**
  - `stallreq = mem_req`. A new post-flush request waits for the bus.
  - `bus_ack` or timeout → clear `bus_stb`, go to IDLE, discard data.
  - `bus_err` is not pulsed on a timeout in ABORT.
- **DONE**
  - `stallreq = 0`; `mem_rdata` = captured data.
  - `stall_i` → stay in DONE, hold data, do not restart the bus.
  - `flush` → IDLE.
  - Otherwise → IDLE (the pipeline advances this cycle).
- `mem_rdata = 0` in all states other than DONE.
- `bus_we/addr/sel/wdata` hold their last values when `bus_stb = 0`.

## Timing

- Reset values: state IDLE; `bus_stb`, `bus_we`, `bus_err` = 0; `bus_addr`, `bus_sel`, `bus_wdata`, captured data, counter = 0.
- `rst` mid-access drops `bus_stb` on the next edge; the outstanding slave ack is ignored.
- Latency with zero-wait slave: request cycle N (stallreq=1), N+1 BUSY with `bus_stb` and `bus_ack`, N+2 DONE (stallreq=0), instruction leaves MEM at end of N+2. Each slave wait state adds one cycle.
- `stallreq` and `mem_rdata` are combinational from state and inputs. All bus outputs are registered.
- The timeout counter is 8-bit, saturates, and is cleared on entry to BUSY only (it continues through ABORT).

## Structure

- The state encoding and `TIMEOUT` default go in the shared defines/package alongside `RegBus`/`ZeroWord`.
- Single module. The 8-bit timeout counter is inline, not a separate sub-module.

## Test plan

- Load, zero-wait: `mem_req=1, we=0, addr=0x100, sel=4'hF`, ack at first `bus_stb`, `rdata=0xDEADBEEF` → `stallreq` high 2 cycles, `mem_rdata=0xDEADBEEF` in 3rd cycle, `bus_stb` high exactly 1 cycle.
- Store, 3 wait states: `we=1, addr=0x204, sel=4'h3, wdata=0x1234` → bus carries those values for 4 cycles, `stallreq` low in cycle 6, `mem_rdata=0`.
- External stall in DONE: `stall_i=1` for 3 cycles after ack → state stays DONE, `mem_rdata` stable, no second `bus_stb`.
- Flush mid-access: `flush` pulse 1 cycle after `bus_stb`, ack 2 cycles later → ABORT entered, `bus_stb` held until ack, data discarded, IDLE afterwards, no `bus_err`.
- Timeout: `TIMEOUT=4`, no ack → `bus_stb` cleared after 4 BUSY cycles, `bus_err` pulses 1 cycle, DONE with `mem_rdata=0`.
- Reset mid-BUSY: `rst` asserted during a wait → next cycle all outputs at reset values; a late `bus_ack` causes no state change.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data bus controller.
package mem_bus_ctrl_pkg;

  localparam int RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam int unsigned TimeoutDefault = 255;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAbort,
    StDone
  } bus_state_e;

endpackage

// File: rtl/mem_bus_ctrl.sv
// Sequences MEM-stage loads/stores onto a req/ack data bus, stalling the pipeline until done.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [RegBus-1:0] mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [RegBus-1:0] mem_wdata,
  input  logic              stall_i,
  input  logic              flush,
  output logic              stallreq,
  output logic [RegBus-1:0] mem_rdata,
  output logic              bus_err,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [RegBus-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [RegBus-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [RegBus-1:0] bus_rdata
);

  bus_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [RegBus-1:0] rdata_q, rdata_d;
  logic              stb_d, we_d, err_d;
  logic [RegBus-1:0] addr_d, wdata_d;
  logic [3:0]        sel_d;
  logic              timeout;

  assign timeout = (cnt_q >= 8'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    stb_d     = bus_stb;
    we_d      = bus_we;
    addr_d    = bus_addr;
    sel_d     = bus_sel;
    wdata_d   = bus_wdata;
    err_d     = 1'b0;
    stallreq  = 1'b0;
    mem_rdata = ZeroWord;

    // Counter saturates and keeps running through ABORT so a dead slave cannot hang us.
    if ((state_q == StBusy || state_q == StAbort) && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        stallreq = mem_req && !flush;
        if (mem_req && !flush) begin
          stb_d   = 1'b1;
          we_d    = mem_we;
          addr_d  = mem_addr;
          sel_d   = mem_sel;
          wdata_d = mem_wdata;
          cnt_d   = 8'd0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        stallreq = 1'b1;
        if (bus_ack) begin
          stb_d = 1'b0;
          if (flush) begin
            state_d = StIdle;
          end else begin
            rdata_d = bus_we ? ZeroWord : bus_rdata;
            state_d = StDone;
          end
        end else if (flush) begin
          // Leave the slave cycle running; it is retired in ABORT.
          state_d = StAbort;
        end else if (timeout) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = ZeroWord;
          state_d = StDone;
        end
      end
      StAbort: begin
        stallreq = mem_req;
        if (bus_ack || timeout) begin
          stb_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StDone: begin
        mem_rdata = rdata_q;
        if (flush || !stall_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      rdata_q   <= ZeroWord;
      bus_stb   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= ZeroWord;
      bus_sel   <= 4'h0;
      bus_wdata <= ZeroWord;
      bus_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_stb   <= stb_d;
      bus_we    <= we_d;
      bus_addr  <= addr_d;
      bus_sel   <= sel_d;
      bus_wdata <= wdata_d;
      bus_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with TIMEOUT=4 and hand-computed expectations.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, stall_i, flush;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic        stallreq, bus_err, bus_stb, bus_we, bus_ack;
  logic [31:0] mem_rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_sel   (mem_sel),
    .mem_wdata (mem_wdata),
    .stall_i   (stall_i),
    .flush     (flush),
    .stallreq  (stallreq),
    .mem_rdata (mem_rdata),
    .bus_err   (bus_err),
    .bus_stb   (bus_stb),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_sel   (bus_sel),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs change here, checks follow a settle delay.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                     input logic [31:0] wdata);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_sel   = sel;
    mem_wdata = wdata;
  endtask

  initial begin
    rst = 1'b1; mem_req = 0; mem_we = 0; mem_addr = 0; mem_sel = 0; mem_wdata = 0;
    stall_i = 0; flush = 0; bus_ack = 0; bus_rdata = 0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_stallreq", 32'(stallreq), 32'd0);
    chk("rst_stb", 32'(bus_stb), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_rdata", mem_rdata, 32'h0);
    tick();

    // Load, zero-wait slave
    req(1'b0, 32'h100, 4'hF, 32'h0);
    settle();
    chk("ld_req_stallreq", 32'(stallreq), 32'd1);
    chk("ld_req_stb", 32'(bus_stb), 32'd0);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    settle();
    chk("ld_busy_stallreq", 32'(stallreq), 32'd1);
    chk("ld_busy_stb", 32'(bus_stb), 32'd1);
    chk("ld_busy_addr", bus_addr, 32'h100);
    chk("ld_busy_sel", 32'(bus_sel), 32'hF);
    chk("ld_busy_we", 32'(bus_we), 32'd0);
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    settle();
    chk("ld_done_stallreq", 32'(stallreq), 32'd0);
    chk("ld_done_rdata", mem_rdata, 32'hDEADBEEF);
    chk("ld_done_stb", 32'(bus_stb), 32'd0);
    tick();
    mem_req = 1'b0;
    settle();
    chk("ld_idle_rdata", mem_rdata, 32'h0);
    chk("ld_idle_stb", 32'(bus_stb), 32'd0);
    chk("ld_idle_addr_hold", bus_addr, 32'h100);
    tick();

    // Store, three wait states; ack lands in the fourth BUSY cycle
    req(1'b1, 32'h204, 4'h3, 32'h1234);
    settle();
    chk("st_req_stallreq", 32'(stallreq), 32'd1);
    tick();
    bus_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      bus_ack = (i == 3);
      settle();
      chk("st_busy_stb", 32'(bus_stb), 32'd1);
      chk("st_busy_we", 32'(bus_we), 32'd1);
      chk("st_busy_addr", bus_addr, 32'h204);
      chk("st_busy_sel", 32'(bus_sel), 32'h3);
      chk("st_busy_wdata", bus_wdata, 32'h1234);
      chk("st_busy_stallreq", 32'(stallreq), 32'd1);
      tick();
    end
    bus_ack = 1'b0; bus_rdata = 32'h0;
    settle();
    chk("st_done_stallreq", 32'(stallreq), 32'd0);
    chk("st_done_rdata", mem_rdata, 32'h0);
    chk("st_done_stb", 32'(bus_stb), 32'd0);
    chk("st_done_err", 32'(bus_err), 32'd0);
    tick();
    mem_req = 1'b0;
    tick();

    // External stall holds DONE
    req(1'b0, 32'h300, 4'hF, 32'h0);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h5A5A1234;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stl_rdata", mem_rdata, 32'h5A5A1234);
      chk("stl_stallreq", 32'(stallreq), 32'd0);
      chk("stl_stb", 32'(bus_stb), 32'd0);
      tick();
    end
    stall_i = 1'b0;
    settle();
    chk("stl_release_rdata", mem_rdata, 32'h5A5A1234);
    chk("stl_release_stb", 32'(bus_stb), 32'd0);
    tick();
    mem_req = 1'b0;
    settle();
    chk("stl_idle_rdata", mem_rdata, 32'h0);
    chk("stl_idle_stb", 32'(bus_stb), 32'd0);
    tick();

    // Flush during an access: ABORT keeps the strobe until the slave acks
    req(1'b0, 32'h400, 4'hF, 32'h0);
    tick();
    settle();
    chk("fl_busy_stb", 32'(bus_stb), 32'd1);
    tick();
    flush = 1'b1;
    settle();
    chk("fl_flush_stallreq", 32'(stallreq), 32'd1);
    tick();
    flush = 1'b0; mem_req = 1'b0;
    settle();
    chk("fl_abort_stb", 32'(bus_stb), 32'd1);
    chk("fl_abort_stallreq", 32'(stallreq), 32'd0);
    chk("fl_abort_rdata", mem_rdata, 32'h0);
    tick();
    mem_req = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h11112222;
    settle();
    chk("fl_ack_stb", 32'(bus_stb), 32'd1);
    chk("fl_ack_stallreq", 32'(stallreq), 32'd1);
    chk("fl_ack_rdata", mem_rdata, 32'h0);
    tick();
    mem_req = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    settle();
    chk("fl_idle_stb", 32'(bus_stb), 32'd0);
    chk("fl_idle_err", 32'(bus_err), 32'd0);
    chk("fl_idle_rdata", mem_rdata, 32'h0);
    chk("fl_idle_stallreq", 32'(stallreq), 32'd0);
    tick();

    // Timeout after four BUSY cycles without ack
    req(1'b0, 32'h500, 4'hF, 32'h0);
    tick();
    bus_rdata = 32'h77777777;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("to_busy_stb", 32'(bus_stb), 32'd1);
      chk("to_busy_err", 32'(bus_err), 32'd0);
      tick();
    end
    settle();
    chk("to_done_stb", 32'(bus_stb), 32'd0);
    chk("to_done_err", 32'(bus_err), 32'd1);
    chk("to_done_rdata", mem_rdata, 32'h0);
    chk("to_done_stallreq", 32'(stallreq), 32'd0);
    tick();
    mem_req = 1'b0; bus_rdata = 32'h0;
    settle();
    chk("to_idle_err", 32'(bus_err), 32'd0);
    chk("to_idle_stb", 32'(bus_stb), 32'd0);
    tick();

    // Reset mid-BUSY; the late ack must be ignored
    req(1'b1, 32'h600, 4'hF, 32'hABCD);
    tick();
    settle();
    chk("rb_busy_stb", 32'(bus_stb), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h99999999;
    settle();
    chk("rb_stb", 32'(bus_stb), 32'd0);
    chk("rb_we", 32'(bus_we), 32'd0);
    chk("rb_addr", bus_addr, 32'h0);
    chk("rb_sel", 32'(bus_sel), 32'h0);
    chk("rb_wdata", bus_wdata, 32'h0);
    chk("rb_stallreq", 32'(stallreq), 32'd0);
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    settle();
    chk("rb_late_stb", 32'(bus_stb), 32'd0);
    chk("rb_late_rdata", mem_rdata, 32'h0);
    chk("rb_late_stallreq", 32'(stallreq), 32'd0);
    chk("rb_late_err", 32'(bus_err), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
